md_sequencer: RTL

Multiply/divide sequencer for the five-stage MIPS pipeline. It owns the HI/LO registers and models the multi-cycle latency of MULT/MULTU/DIV/DIVU. It accepts one operation per start pulse from the E stage and holds busy for a fixed number of cycles. It also drives the stall request to the hazard logic when a D-stage instruction needs the unit (mult/div/mfhi/mflo/mthi/mtlo) while the unit is occupied.

---
 rtl/md_sequencer_pkg.sv | 35 +++
 rtl/md_sequencer_arith.sv | 74 +++++++
 rtl/md_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/md_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// md_sequencer_pkg
// Shared definitions for the multiply/divide sequencer of the MIPS pipeline.
//   - md_op_e    : encodings of the md_op field presented by the E stage
//   - md_state_e : sequencer FSM states
//   - is_arith_op: true for MULT/MULTU/DIV/DIVU, the ops that occupy the unit
//   - is_mult_op : among the arithmetic ops, true for MULT/MULTU
// ----------------------------------------------------------------------------
package md_sequencer_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Ops 0-3 all have bit 2 clear; 4-7 are moves or reserved.
    function automatic logic is_arith_op(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    // Within the arithmetic group, bit 1 separates multiply from divide.
    function automatic logic is_mult_op(input logic [2:0] op);
        return (op[1] == 1'b0);
    endfunction

endpackage

// File: rtl/md_sequencer_arith.sv
// ----------------------------------------------------------------------------
// md_arith
// Purely combinational datapath for MULT/MULTU/DIV/DIVU.
// Ports:
//   op          in   2  low bits of md_op: 0=MULT 1=MULTU 2=DIV 3=DIVU
//   a           in  32  rs operand (multiplicand / dividend)
//   b           in  32  rt operand (multiplier / divisor)
//   result      out 64  {hi, lo}: product, or {remainder, quotient}
//   div_by_zero out  1  divide op with b == 0; result must be ignored
// ----------------------------------------------------------------------------
module md_arith (
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic        is_signed;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        signed_overflow;

    // MULT and DIV are the even encodings.
    assign is_signed = ~op[0];

    // A 64x64 multiply of sign- or zero-extended operands gives the correct
    // low 64 bits for both signed and unsigned products without relying on
    // the signedness rules of the multiply operator.
    assign a_ext   = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    assign b_ext   = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    assign product = a_ext * b_ext;

    // Signed division is done on magnitudes and the signs are re-applied:
    // quotient truncates toward zero, remainder follows the dividend.
    // The magnitude of 0x80000000 is 0x80000000 as an unsigned value.
    assign a_neg = is_signed & a[31];
    assign b_neg = is_signed & b[31];
    assign a_mag = a_neg ? (~a + 32'd1) : a;
    assign b_mag = b_neg ? (~b + 32'd1) : b;

    // Divide by a harmless 1 when b is zero; the result is discarded anyway
    // and this keeps the divider free of X propagation.
    assign div_by_zero = op[1] & (b == 32'd0);
    assign divisor     = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag       = a_mag / divisor;
    assign r_mag       = a_mag % divisor;

    // The one signed quotient that does not fit in 32 bits.
    assign signed_overflow = is_signed & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);

    always_comb begin
        quotient  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        remainder = a_neg ? (~r_mag + 32'd1) : r_mag;
        if (signed_overflow) begin
            quotient  = 32'h8000_0000;
            remainder = 32'd0;
        end
    end

    assign result = op[1] ? {remainder, quotient} : product;

endmodule

// File: rtl/md_sequencer.sv
// ----------------------------------------------------------------------------
// md_sequencer
// Multiply/divide sequencer: owns HI/LO, models the multi-cycle latency of
// MULT/MULTU/DIV/DIVU and raises a stall request for D-stage instructions
// that need the unit while it is occupied.
// Parameters:
//   MULT_CYCLES  busy duration for MULT/MULTU (>=1)
//   DIV_CYCLES   busy duration for DIV/DIVU (>=1)
// Ports:
//   clk        in   1  clock
//   reset      in   1  synchronous, active-high reset
//   start      in   1  E-stage strobe, md_op valid this cycle
//   md_op      in   3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6-7 no-op
//   rs_val     in  32  rs operand / MTHI-MTLO source
//   rt_val     in  32  rt operand
//   d_uses_md  in   1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
//   busy       out  1  operation in progress
//   stall      out  1  stall request to the hazard unit
//   hi, lo     out 32  architectural HI/LO registers
// ----------------------------------------------------------------------------
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_uses_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_valid_q, pend_valid_d;

    logic [63:0] arith_result;
    logic        arith_div_by_zero;

    md_arith u_arith (
        .op          (md_op[1:0]),
        .a           (rs_val),
        .b           (rt_val),
        .result      (arith_result),
        .div_by_zero (arith_div_by_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            pend_hi_q    <= '0;
            pend_lo_q    <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            pend_hi_q    <= pend_hi_d;
            pend_lo_q    <= pend_lo_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        pend_hi_d    = pend_hi_q;
        pend_lo_d    = pend_lo_q;
        pend_valid_d = pend_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (start && is_arith_op(md_op)) begin
                    // Compute now, reveal later: the result waits in the
                    // pending registers until the latency has elapsed.
                    pend_hi_d    = arith_result[63:32];
                    pend_lo_d    = arith_result[31:0];
                    pend_valid_d = ~arith_div_by_zero;
                    cnt_d        = is_mult_op(md_op) ? CNT_W'(MULT_CYCLES)
                                                     : CNT_W'(DIV_CYCLES);
                    state_d      = ST_RUN;
                end else if (start && (md_op == MD_MTHI)) begin
                    hi_d = rs_val;
                end else if (start && (md_op == MD_MTLO)) begin
                    lo_d = rs_val;
                end
            end

            ST_RUN: begin
                // Any start seen here is ignored; upstream stalling keeps
                // it from happening in normal operation.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d      = ST_IDLE;
                    pend_valid_d = 1'b0;
                    if (pend_valid_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy  = (state_q == ST_RUN);
    // Covers the start cycle itself, before busy has risen.
    assign stall = d_uses_md & (busy | (start & is_arith_op(md_op)));
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
